// File: rtl/romtile_pkg.sv
// romtile_pkg: shared definitions for the ROM tile read arbiter.
// Holds the requester-address to ROM-address remap field positions, the
// tag record that follows each ROM read, and the 4-bit to 16-bit pixel unpack.
package romtile_pkg;

    // Requester address bits copied into the ROM address.
    localparam int unsigned REMAP_HI_LSB  = 5;   // addr[ROMAW:5] -> romaddr MSBs
    localparam int unsigned REMAP_LO_W    = 3;   // addr[2:0]     -> romaddr middle
    localparam int unsigned REMAP_INV_BIT = 4;   // ~addr[4]      -> romaddr LSB

    localparam int unsigned CHW   = 3;           // channel index width (up to 8 channels)
    localparam int unsigned DATAW = 16;          // unpacked pixel word width

    // Tag carried alongside a ROM read until its data returns.
    typedef struct packed {
        logic           valid;
        logic [CHW-1:0] ch;
        logic           flip;
    } tag_t;

    // Spread four 1-bit pixels into 4-bit lanes; flip mirrors the pixel order.
    function automatic logic [DATAW-1:0] unpack_px(input logic [3:0] d, input logic flip);
        if (flip) begin
            return {3'b0, d[3], 3'b0, d[2], 3'b0, d[1], 3'b0, d[0]};
        end
        return {3'b0, d[0], 3'b0, d[1], 3'b0, d[2], 3'b0, d[3]};
    endfunction

endpackage

// File: rtl/romtile_arb_rr.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   eligible [N]  - channels allowed to win this cycle
//   last     [IW] - index of the most recent winner; search starts just after it
//   grant    [N]  - one-hot winner (zero when nothing eligible)
//   valid         - a winner exists
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Walk the channels starting after 'last', wrapping to 0; first hit wins.
    always_comb begin
        int unsigned idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(last) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && eligible[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/romtile_arb.sv
// romtile_arb: shares one external tile ROM among NCH requesters.
// Each cycle at most one eligible channel is granted round-robin; its address
// is remapped onto the ROM, a tag follows the read through a LAT-deep pipe,
// and when the data returns it is unpacked and acked to the owning channel.
// Ports:
//   clk, rst          - clock, async active-high reset
//   req/addr/flip     - per-channel level request, address, horizontal flip
//   ack/data          - one-cycle completion pulse and unpacked pixel word
//   romrden/romaddr   - ROM read enable and address (registered)
//   romdata           - ROM nibble, valid LAT cycles after the address edge
module romtile_arb
    import romtile_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned AW    = 17,
    parameter int unsigned ROMAW = 12,
    parameter int unsigned LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req,
    input  logic [NCH*AW-1:0]  addr,
    input  logic [NCH-1:0]     flip,
    output logic [NCH-1:0]     ack,
    output logic [DATAW-1:0]   data,
    output logic               romrden,
    output logic [ROMAW-1:0]   romaddr,
    input  logic [3:0]         romdata
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    // pipe[0] is loaded on the grant edge; pipe[LAT] lines up with romdata.
    tag_t [LAT:0]     pipe;
    tag_t             tail;
    logic [IW-1:0]    last;
    logic [NCH-1:0]   inflight;
    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   gnt;
    logic             gvalid;
    logic [IW-1:0]    gidx;
    logic [AW-1:0]    sel_addr;
    logic             sel_flip;
    logic [ROMAW-1:0] remap;
    logic [NCH-1:0]   ack_n;
    logic             unused_addr;

    // A channel is busy from its grant until its tag leaves the pipe.
    always_comb begin
        inflight = '0;
        for (int unsigned s = 0; s <= LAT; s++) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pipe[s].valid && pipe[s].ch == CHW'(i)) begin
                    inflight[i] = 1'b1;
                end
            end
        end
    end

    // The ack cycle is also blocked so the requester can swap address first.
    assign eligible = req & ~inflight & ~ack;

    rr_arbiter #(.N(NCH)) u_rr (
        .eligible (eligible),
        .last     (last),
        .grant    (gnt),
        .valid    (gvalid)
    );

    // One-hot grant to index.
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                gidx = IW'(i);
            end
        end
    end

    assign sel_addr = addr[32'(gidx)*AW +: AW];
    assign sel_flip = flip[gidx];

    // Bit 3 and bits above ROMAW select nothing in the ROM.
    assign remap = {sel_addr[ROMAW:REMAP_HI_LSB],
                    sel_addr[REMAP_LO_W-1:0],
                    ~sel_addr[REMAP_INV_BIT]};
    assign unused_addr = ^sel_addr;

    assign tail = pipe[LAT];

    // Completion pulse for the channel whose tag is at the pipe tail.
    always_comb begin
        ack_n = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ack_n[i] = tail.valid && (tail.ch == CHW'(i));
        end
    end

    // Grant, tag pipeline and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe    <= '0;
            last    <= IW'(NCH - 1);
            ack     <= '0;
            data    <= '0;
            romrden <= 1'b0;
            romaddr <= '0;
        end else begin
            pipe[0] <= '{valid: gvalid, ch: CHW'(gidx), flip: sel_flip};
            for (int unsigned s = 1; s <= LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
            romrden <= gvalid;
            if (gvalid) begin
                romaddr <= remap;
                last    <= gidx;
            end
            ack <= ack_n;
            if (tail.valid) begin
                data <= unpack_px(romdata, tail.flip);
            end
        end
    end

endmodule
